mux_stream: RTL and testbench

Parametrised N-channel streaming multiplexer with valid/ready handshakes and a one-entry registered output stage. It is the successor to the plain 4:1 combinational select mux. It adds parametrised width and channel count, back-pressure, and a runtime-selectable round-robin mode. It sits between several producer streams and a single consumer, for example ahead of a shared FIFO or UART transmitter.

---
 rtl/mux_stream_pkg.sv | 11 +
 rtl/mux_stream_rr_pick.sv | 34 +++
 rtl/mux_stream.sv | 97 +++++++++
 tb/tb_mux_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// Shared definitions for the mux_stream block: mode encodings and select-width helper.
package mux_stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_stream_rr_pick.sv
// Round-robin picker: rotates the request vector to start just after 'last',
// then priority-encodes the lowest set bit and maps it back to a channel index.
module rr_pick
  import mux_stream_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [SELW:0] off;
  logic [SELW:0] sum;

  // bit j of rot is channel (last+1+j) mod N
  assign rot = N'({req, req} >> (32'(last) + 32'd1));

  always_comb begin
    found = |rot;
    off   = '0;
    sum   = '0;
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = (SELW+1)'(j);
    end
    sum = {1'b0, last} + off + (SELW+1)'(1);
    idx = SELW'((sum >= (SELW+1)'(N)) ? sum - (SELW+1)'(N) : sum);
  end

endmodule

// File: rtl/mux_stream.sv
// N-channel streaming mux with a one-entry registered output stage.
// Define MUX_STREAM_RR_EN to enable the runtime-selectable round-robin mode.
module mux_stream
  import mux_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   grant
);

  logic             load;
  logic             accept;
  logic             sel_ok;
  logic             pick_valid;
  logic [SELW-1:0]  pick_idx;
  logic [WIDTH-1:0] chan_data;

  assign load   = ~out_valid | out_ready;
  assign sel_ok = (32'(sel) < N);

`ifdef MUX_STREAM_RR_EN
  logic [SELW-1:0] last;
  logic [SELW-1:0] rr_idx;
  logic            rr_found;

  rr_pick #(.N(N)) u_pick (
    .req   (in_valid),
    .last  (last),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    pick_valid = sel_ok;
    pick_idx   = sel;
    if (mode == MODE_RR) begin
      pick_valid = rr_found;
      pick_idx   = rr_idx;
    end
  end

  // Reset to N-1 so the first round-robin search begins at channel 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= SELW'(N - 1);
    end else if (accept) begin
      last <= pick_idx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign pick_valid  = sel_ok;
  assign pick_idx    = sel;
`endif

  always_comb begin
    in_ready  = '0;
    chan_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_valid && (pick_idx == SELW'(i))) begin
        in_ready[i] = load;
        chan_data   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = |(in_ready & in_valid);

  // A new beat may replace a draining one in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= chan_data;
      grant     <= pick_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_stream.sv
// Directed bench for mux_stream: 4-channel instance for the main checks and a
// 3-channel instance for the out-of-range select case.
module tb_mux_stream;

  logic        clk;
  logic        rst;
  logic [1:0]  sel;
  logic        mode;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant;

  logic [1:0]  sel_b;
  logic        mode_b;
  logic [23:0] in_data_b;
  logic [2:0]  in_valid_b;
  logic [2:0]  in_ready_b;
  logic [7:0]  out_data_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [1:0]  grant_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_g;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] chan[4];
  logic [1:0] rr_seq[6];
  logic [1:0] alt_seq[4];

  mux_stream #(.WIDTH(8), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant)
  );

  mux_stream #(.WIDTH(8), .N(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel_b),
    .mode      (mode_b),
    .in_data   (in_data_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .out_data  (out_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .grant     (grant_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRegs(input string name, input logic ov, input logic [7:0] od, input logic [1:0] g);
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'(ov));
    checkOutput({name, " out_data"}, 32'(out_data), 32'(od));
    checkOutput({name, " grant"}, 32'(grant), 32'(g));
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic m, input logic [3:0] v, input logic ordy);
    sel       = s;
    mode      = m;
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chan[0] = 8'h11; chan[1] = 8'h22; chan[2] = 8'hA5; chan[3] = 8'h3C;
    in_data = {chan[3], chan[2], chan[1], chan[0]};

    vecs[0] = '{2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1] = '{2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2};
    vecs[2] = '{2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[3] = '{2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h11, 2'd0};
    vecs[4] = '{2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h3C, 2'd3};
    vecs[5] = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[6] = '{2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h22, 2'd1};
    vecs[7] = '{2'd2, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'h22, 2'd1};

    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2;
    rr_seq[3] = 2'd3; rr_seq[4] = 2'd0; rr_seq[5] = 2'd1;
    alt_seq[0] = 2'd3; alt_seq[1] = 2'd1; alt_seq[2] = 2'd3; alt_seq[3] = 2'd1;

    rst = 1'b1;
    applyStimulus(2'd0, 1'b0, 4'b0000, 1'b0);
    sel_b       = 2'd3;
    mode_b      = 1'b0;
    in_data_b   = {8'h77, 8'h66, 8'h55};
    in_valid_b  = 3'b000;
    out_ready_b = 1'b0;

    repeat (2) stepCycle();
    checkRegs("reset", 1'b0, 8'h00, 2'd0);
    checkOutput("reset n3 out_valid", 32'(out_valid_b), 32'd0);
    rst = 1'b0;

    // Fixed-select vectors, including back-pressure and drain without accept
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sel, 1'b0, vecs[i].valid, vecs[i].ordy);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      stepCycle();
      checkRegs($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_g);
    end

    // Stall: load ch1, hold three cycles while sel moves to 3, then drain+accept
    applyStimulus(2'd1, 1'b0, 4'b1111, 1'b0);
    #1;
    checkOutput("stall load in_ready", 32'(in_ready), 32'b0010);
    stepCycle();
    checkRegs("stall load", 1'b1, 8'h22, 2'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus((k == 0) ? 2'd1 : 2'd3, 1'b0, 4'b1111, 1'b0);
      #1;
      checkOutput($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'b0000);
      stepCycle();
      checkRegs($sformatf("stall%0d", k), 1'b1, 8'h22, 2'd1);
    end
    applyStimulus(2'd3, 1'b0, 4'b1111, 1'b1);
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'b1000);
    stepCycle();
    checkRegs("release", 1'b1, 8'h3C, 2'd3);
    applyStimulus(2'd3, 1'b0, 4'b0000, 1'b1);
    stepCycle();
    checkRegs("drain", 1'b0, 8'h3C, 2'd3);

    // Three-channel instance: sel=3 is out of range, sel=2 is the last channel
    in_valid_b  = 3'b111;
    out_ready_b = 1'b1;
    #1;
    checkOutput("n3 sel3 in_ready", 32'(in_ready_b), 32'b000);
    stepCycle();
    checkOutput("n3 sel3 out_valid", 32'(out_valid_b), 32'd0);
    stepCycle();
    checkOutput("n3 sel3 out_valid2", 32'(out_valid_b), 32'd0);
    sel_b = 2'd2;
    #1;
    checkOutput("n3 sel2 in_ready", 32'(in_ready_b), 32'b100);
    stepCycle();
    checkOutput("n3 sel2 out_valid", 32'(out_valid_b), 32'd1);
    checkOutput("n3 sel2 out_data", 32'(out_data_b), 32'h77);
    checkOutput("n3 sel2 grant", 32'(grant_b), 32'd2);

`ifdef MUX_STREAM_RR_EN
    rst = 1'b1;
    #2;
    rst = 1'b0;
    // All channels valid from reset: 0,1,2,3,0,1 with no bubbles
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'd0, 1'b1, 4'b1111, 1'b1);
      #1;
      checkOutput($sformatf("rr%0d in_ready", k), 32'(in_ready), 32'(4'b0001 << rr_seq[k]));
      stepCycle();
      checkRegs($sformatf("rr%0d", k), 1'b1, chan[rr_seq[k]], rr_seq[k]);
    end
    // Sparse requests after last=1: alternate 3,1
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'd0, 1'b1, 4'b1010, 1'b1);
      #1;
      checkOutput($sformatf("alt%0d in_ready", k), 32'(in_ready), 32'(4'b0001 << alt_seq[k]));
      stepCycle();
      checkRegs($sformatf("alt%0d", k), 1'b1, chan[alt_seq[k]], alt_seq[k]);
    end
    // Fixed-mode cycle without accept, then back to round-robin: last=1 retained
    applyStimulus(2'd2, 1'b0, 4'b0000, 1'b1);
    #1;
    checkOutput("switch fixed in_ready", 32'(in_ready), 32'b0100);
    stepCycle();
    checkRegs("switch fixed", 1'b0, chan[1], 2'd1);
    applyStimulus(2'd0, 1'b1, 4'b1111, 1'b1);
    #1;
    checkOutput("switch rr in_ready", 32'(in_ready), 32'b0100);
    stepCycle();
    checkRegs("switch rr", 1'b1, chan[2], 2'd2);
`else
    // Without round-robin support mode is ignored
    applyStimulus(2'd2, 1'b1, 4'b1111, 1'b1);
    #1;
    checkOutput("mode ignored in_ready", 32'(in_ready), 32'b0100);
    stepCycle();
    checkRegs("mode ignored", 1'b1, chan[2], 2'd2);
`endif

    // Reset while a beat is stalled clears the outputs immediately
    applyStimulus(2'd0, 1'b0, 4'b0000, 1'b1);
    stepCycle();
    applyStimulus(2'd2, 1'b0, 4'b1111, 1'b0);
    stepCycle();
    checkRegs("pre-reset", 1'b1, chan[2], 2'd2);
    #2;
    rst = 1'b1;
    #1;
    checkRegs("async reset", 1'b0, 8'h00, 2'd0);
    #2;
    rst = 1'b0;
    applyStimulus(2'd2, 1'b1, 4'b1111, 1'b1);
    stepCycle();
`ifdef MUX_STREAM_RR_EN
    checkRegs("post-reset", 1'b1, chan[0], 2'd0);
`else
    checkRegs("post-reset", 1'b1, chan[2], 2'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
